// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI master arbiter.
//   state_e  - arbiter FSM states
//   TMO_RESP - response word returned when the SPI master times out
//   SEL_*    - slave-select routing codes
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RETURN,
    GAP
  } state_e;

  localparam logic [15:0] TMO_RESP = 16'hDEAD;

  localparam logic SEL_NEMO = 1'b0;
  localparam logic SEL_A2D  = 1'b1;

endpackage

// File: rtl/spi_arb_tmr.sv
// spi_arb_tmr: loadable down-counter, shared by the BUSY timeout and GAP count.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load load_val (has priority over en)
//   en        - decrement by one, holding at zero
//   load_val  - value to load
//   zero      - counter currently at zero
module spi_arb_tmr #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_arb.sv
// spi_arb: arbitrates one shared SPI master between the inertial interface
// (req0, high priority) and the A2D interface (req1), with a starvation guard,
// an inter-frame gap and a BUSY timeout.
//   req0/cmd0/done0 - inertial requester handshake
//   req1/cmd1/done1 - A2D requester handshake
//   rd_data, err    - response word and timeout flag (err coincides with doneN)
//   m_snd/m_cmd     - launch pulse and command to the SPI master
//   m_resp/m_done   - response and completion pulse from the SPI master
//   ss_sel          - slave routing, 0 = NEMO, 1 = A2D
// Optional: define SPI_ARB_STATS_EN to add gnt_cnt0, gnt_cnt1 and tmo_cnt.
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned GAP_CYC    = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] cmd0,
  output logic        done0,
  input  logic        req1,
  input  logic [15:0] cmd1,
  output logic        done1,
  output logic [15:0] rd_data,
  output logic        err,
  output logic        m_snd,
  output logic [15:0] m_cmd,
  input  logic [15:0] m_resp,
  input  logic        m_done,
  output logic        ss_sel
`ifdef SPI_ARB_STATS_EN
  ,
  output logic [15:0] gnt_cnt0,
  output logic [15:0] gnt_cnt1,
  output logic [7:0]  tmo_cnt
`endif
);

  localparam int unsigned TMR_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int unsigned TW      = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned SW      = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  state_e        state_q, state_d;
  logic          ss_sel_q, ss_sel_d;
  logic [15:0]   m_cmd_q, m_cmd_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          err_flag_q, err_flag_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          arb_ok, pick1, grant;

  spi_arb_tmr #(.W(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign pick1 = req1 && (!req0 || (starve_q == SW'(STARVE_MAX)));
  assign grant = arb_ok && (req0 || req1);

  always_comb begin
    state_d    = state_q;
    ss_sel_d   = ss_sel_q;
    m_cmd_d    = m_cmd_q;
    rd_data_d  = rd_data_q;
    err_flag_d = err_flag_q;
    starve_d   = starve_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_val    = '0;
    arb_ok     = 1'b0;

    unique case (state_q)
      IDLE: arb_ok = 1'b1;
      LAUNCH: begin
        tmr_load   = 1'b1;
        tmr_val    = TW'(TIMEOUT - 1);
        err_flag_d = 1'b0;
        state_d    = BUSY;
      end
      BUSY: begin
        tmr_en = 1'b1;
        if (m_done) begin
          rd_data_d = m_resp;
          state_d   = RETURN;
        end else if (tmr_zero) begin
          rd_data_d  = TMO_RESP;
          err_flag_d = 1'b1;
          state_d    = RETURN;
        end
      end
      RETURN: begin
        if (GAP_CYC == 0) begin
          state_d = IDLE;
        end else begin
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYC - 1);
          state_d  = GAP;
        end
      end
      GAP: begin
        tmr_en = 1'b1;
        // The last gap cycle arbitrates as IDLE would, so the next launch
        // follows the previous done by exactly GAP_CYC idle clocks.
        if (tmr_zero) begin
          state_d = IDLE;
          arb_ok  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d  = LAUNCH;
      ss_sel_d = pick1 ? SEL_A2D : SEL_NEMO;
      m_cmd_d  = pick1 ? cmd1 : cmd0;
      if (pick1 || !req1) begin
        starve_d = '0;
      end else if (starve_q != SW'(STARVE_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ss_sel_q   <= SEL_NEMO;
      m_cmd_q    <= '0;
      rd_data_q  <= '0;
      err_flag_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      ss_sel_q   <= ss_sel_d;
      m_cmd_q    <= m_cmd_d;
      rd_data_q  <= rd_data_d;
      err_flag_q <= err_flag_d;
      starve_q   <= starve_d;
    end
  end

  assign m_snd   = (state_q == LAUNCH);
  assign done0   = (state_q == RETURN) && (ss_sel_q == SEL_NEMO);
  assign done1   = (state_q == RETURN) && (ss_sel_q == SEL_A2D);
  assign err     = (state_q == RETURN) && err_flag_q;
  assign rd_data = rd_data_q;
  assign m_cmd   = m_cmd_q;
  assign ss_sel  = ss_sel_q;

`ifdef SPI_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0] gnt_cnt1_q, gnt_cnt1_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        tmo_hit;

  assign tmo_hit = (state_q == BUSY) && !m_done && tmr_zero;

  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (grant && !pick1 && (gnt_cnt0_q != '1)) gnt_cnt0_d = gnt_cnt0_q + 1'b1;
    if (grant && pick1 && (gnt_cnt1_q != '1))  gnt_cnt1_d = gnt_cnt1_q + 1'b1;
    if (tmo_hit && (tmo_cnt_q != '1))          tmo_cnt_d  = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
  assign tmo_cnt  = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_spi_arb.sv
module tb_spi_arb;
  import spi_arb_pkg::*;

  localparam int unsigned GAP_CYC = 2;
  localparam int unsigned TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst, req0, req1, m_done;
  logic [15:0] cmd0, cmd1, m_resp;
  logic        done0, done1, err, m_snd, ss_sel;
  logic [15:0] rd_data, m_cmd;
`ifdef SPI_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
  logic [7:0]  tmo_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  spi_arb #(.STARVE_MAX(4), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .cmd0    (cmd0),
    .done0   (done0),
    .req1    (req1),
    .cmd1    (cmd1),
    .done1   (done1),
    .rd_data (rd_data),
    .err     (err),
    .m_snd   (m_snd),
    .m_cmd   (m_cmd),
    .m_resp  (m_resp),
    .m_done  (m_done),
    .ss_sel  (ss_sel)
`ifdef SPI_ARB_STATS_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1),
    .tmo_cnt  (tmo_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance negedges until m_snd is seen; returns the number of edges waited.
  task automatic wait_snd(input string tag, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (m_snd) break;
    end
    check(tag, m_snd, 1);
  endtask

  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (done0 || done1) break;
    end
    check(tag, done0 | done1, 1);
  endtask

  // SPI master model: completes dly clocks after the launch cycle.
  task automatic master(input int dly, input logic [15:0] resp);
    repeat (dly) @(negedge clk);
    m_resp = resp;
    m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
  endtask

`ifdef SPI_ARB_STATS_EN
  task automatic txn(input logic sel, input int dly);
    if (sel) req1 = 1'b1; else req0 = 1'b1;
    wait_snd("st_snd", 10, cyc);
    if (dly > 0) master(dly, 16'h0101);
    else wait_done("st_tmo_done", TIMEOUT + 10, cyc);
    check("st_done", {done1, done0}, sel ? 2'b10 : 2'b01);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (GAP_CYC) @(negedge clk);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; cmd0 = '0; cmd1 = '0;
    m_done = 1'b0; m_resp = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {m_snd, done0, done1, err, ss_sel}, 5'b0);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_m_cmd", m_cmd, 16'h0000);
    check("rst_state", dut.state_q, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Single inertial request.
    req0 = 1'b1; cmd0 = 16'h8F00;
    @(negedge clk);
    check("t1_snd", m_snd, 1);
    check("t1_ss_sel", ss_sel, SEL_NEMO);
    check("t1_m_cmd", m_cmd, 16'h8F00);
    master(40, 16'h1234);
    check("t1_done", {done1, done0}, 2'b01);
    check("t1_rd_data", rd_data, 16'h1234);
    check("t1_err", err, 0);
    req0 = 1'b0;
    @(negedge clk);
    check("t1_done_pulse", {done1, done0, m_snd}, 3'b000);
    repeat (GAP_CYC) @(negedge clk);

    // m_done while idle must be ignored.
    m_resp = 16'hFFFF; m_done = 1'b1;
    @(negedge clk);
    m_done = 1'b0;
    @(negedge clk);
    check("idle_mdone_outs", {done1, done0, err}, 3'b000);
    check("idle_mdone_rd", rd_data, 16'h1234);

    // Simultaneous requests: req0 first, req1 after the gap.
    req0 = 1'b1; req1 = 1'b1; cmd0 = 16'h1111; cmd1 = 16'h2222;
    @(negedge clk);
    check("t2_snd0", m_snd, 1);
    check("t2_ss_sel0", ss_sel, SEL_NEMO);
    check("t2_m_cmd0", m_cmd, 16'h1111);
    master(5, 16'hAAAA);
    check("t2_done0", {done1, done0}, 2'b01);
    check("t2_rd0", rd_data, 16'hAAAA);
    req0 = 1'b0;
    wait_snd("t2_snd1", 20, cyc);
    check("t2_gap_len", cyc, GAP_CYC + 1);
    check("t2_ss_sel1", ss_sel, SEL_A2D);
    check("t2_m_cmd1", m_cmd, 16'h2222);
    master(3, 16'h5555);
    check("t2_done1", {done1, done0}, 2'b10);
    check("t2_rd1", rd_data, 16'h5555);
    req1 = 1'b0;
    repeat (GAP_CYC) @(negedge clk);

    // Starvation: req0 re-raised after every done0 while req1 is held.
    req0 = 1'b1; req1 = 1'b1; cmd0 = 16'h0A0A; cmd1 = 16'h0B0B;
    for (int i = 1; i <= 5; i++) begin
      wait_snd("t3_snd", 20, cyc);
      check("t3_ss_sel", ss_sel, (i == 5) ? 1 : 0);
      master(2, 16'(i));
      check("t3_done", {done1, done0}, (i == 5) ? 2'b10 : 2'b01);
      check("t3_rd", rd_data, i);
      if (i < 5) begin
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1;
      end else begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    repeat (GAP_CYC) @(negedge clk);

    // Timeout: master never completes.
    req1 = 1'b1; cmd1 = 16'h0C00;
    wait_snd("t4_snd", 5, cyc);
    wait_done("t4_done_seen", TIMEOUT + 100, cyc);
    check("t4_latency", cyc, TIMEOUT + 1);
    check("t4_done1", {done1, done0}, 2'b10);
    check("t4_rd", rd_data, 16'hDEAD);
    check("t4_err", err, 1);
    req1 = 1'b0;
    @(negedge clk);
    check("t4_err_pulse", err, 0);
    repeat (GAP_CYC) @(negedge clk);

    // Reset while BUSY.
    req0 = 1'b1; cmd0 = 16'h7700;
    wait_snd("t5_snd", 5, cyc);
    @(negedge clk);
    check("t5_busy", dut.state_q, BUSY);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("t5_state", dut.state_q, IDLE);
    check("t5_outs", {done0, done1, err, m_snd}, 4'b0);
    check("t5_rd", rd_data, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_done = (i == 0);
      @(negedge clk);
      check("t5_quiet", {done0, done1, err, m_snd}, 4'b0);
    end
    m_done = 1'b0;
    req0 = 1'b1; cmd0 = 16'h9100;
    wait_snd("t5_snd2", 5, cyc);
    check("t5_m_cmd", m_cmd, 16'h9100);
    master(10, 16'h4321);
    check("t5_done", {done1, done0}, 2'b01);
    check("t5_rd2", rd_data, 16'h4321);
    check("t5_err", err, 0);
    req0 = 1'b0;
    repeat (GAP_CYC) @(negedge clk);

`ifdef SPI_ARB_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("st_clear", {gnt_cnt0, gnt_cnt1, tmo_cnt}, 40'h0);
    txn(1'b0, 4);
    txn(1'b0, 4);
    txn(1'b1, 4);
    txn(1'b0, 4);
    txn(1'b1, 0);
    check("st_gnt0", gnt_cnt0, 3);
    check("st_gnt1", gnt_cnt1, 2);
    check("st_tmo", tmo_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
